// File: rtl/spi_dac_pkg.sv
// Shared types and helpers for the SPI DAC arbiter slice: FSM state encoding,
// frame width derivation, gap length derivation and SPI mode 0 idle levels.
package spi_dac_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  // Mode 0: sck idles low; chip select idles high (deasserted)
  localparam logic SCK_IDLE = 1'b0;
  localparam logic CSN_IDLE = 1'b1;

  function automatic int frame_width(input int aw, input int dw);
    return aw + dw;
  endfunction

  // The latch strobe must finish inside the gap, so the gap stretches when it is enabled
  function automatic int gap_len(input int csn_gap, input int sck_div, input bit ldac_en);
    return (ldac_en && (sck_div + 1 > csn_gap)) ? sck_div + 1 : csn_gap;
  endfunction

endpackage

// File: rtl/spi_dac_arbiter_if.sv
// Requester handshake and DAC pin bundle; the arbiter uses the slave view,
// requesters and the DAC side use the master view.
interface spi_dac_arbiter_if #(
  parameter int N_REQ      = 3,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 4
);
  logic [N_REQ-1:0]            req;
  logic [N_REQ*DATA_WIDTH-1:0] wdat;
  logic [N_REQ*ADDR_WIDTH-1:0] waddr;
  logic [N_REQ-1:0]            gnt;
  logic                        done;
  logic                        busy;
  logic                        sck;
  logic                        mosi;
  logic                        csn;
  logic                        ldacn;

  modport slave (
    input  req, wdat, waddr,
    output gnt, done, busy, sck, mosi, csn, ldacn
  );

  modport master (
    output req, wdat, waddr,
    input  gnt, done, busy, sck, mosi, csn, ldacn
  );
endinterface

// File: rtl/spi_frame_tx.sv
// Frame serializer: sck divider, MSB-first shift register, csn framing, gap pacing,
// done pulse and the optional DAC latch strobe (SPI_DAC_ARB_LDAC_EN).
//
// state | meaning
// IDLE  | csn high, waiting for load
// SETUP | csn low, first bit on mosi, SCK_DIV cycles before first rising edge
// SHIFT | sck toggles every SCK_DIV cycles; mosi advances on each falling edge
// GAP   | csn high, done pulsed on entry, holds off the next load
module spi_frame_tx
  import spi_dac_pkg::*;
#(
  parameter int FW      = 16,
  parameter int SCK_DIV = 2,
  parameter int CSN_GAP = 2
) (
  input  logic          clk,
  input  logic          arstn,
  input  logic          load,
  input  logic [FW-1:0] frame,
  output logic          busy,
  output logic          done,
  output logic          sck,
  output logic          mosi,
  output logic          csn,
  output logic          ldacn
);

`ifdef SPI_DAC_ARB_LDAC_EN
  localparam bit LDAC_EN = 1'b1;
`else
  localparam bit LDAC_EN = 1'b0;
`endif
  localparam int GAP_LEN = gap_len(CSN_GAP, SCK_DIV, LDAC_EN);
  localparam int CW      = 16;
  localparam int BW      = $clog2(FW + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [FW-1:0] sh;

  // Zeros shift in behind the frame, so mosi is already 0 once the last bit is out
  assign mosi = sh[FW-1];

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sck     <= SCK_IDLE;
      csn     <= CSN_IDLE;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            state   <= SETUP;
            busy    <= 1'b1;
            csn     <= ~CSN_IDLE;
            sh      <= frame;
            cnt     <= CW'(SCK_DIV - 1);
            bit_cnt <= BW'(FW - 1);
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state <= SHIFT;
            sck   <= ~SCK_IDLE;
            cnt   <= CW'(SCK_DIV - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (sck) begin
            sck <= 1'b0;
            sh  <= {sh[FW-2:0], 1'b0};
            cnt <= CW'(SCK_DIV - 1);
          end else if (bit_cnt == '0) begin
            state <= GAP;
            csn   <= CSN_IDLE;
            done  <= 1'b1;
            sh    <= '0;
            cnt   <= CW'(GAP_LEN - 1);
          end else begin
            bit_cnt <= bit_cnt - BW'(1);
            sck     <= 1'b1;
            cnt     <= CW'(SCK_DIV - 1);
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_DAC_ARB_LDAC_EN
  logic          last_edge;
  logic [CW-1:0] ldac_cnt;

  // Asserted in the cycle before csn rises, so ldacn falls together with csn rising
  assign last_edge = (state == SHIFT) && (cnt == '0) && !sck && (bit_cnt == '0);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      ldacn    <= 1'b1;
      ldac_cnt <= '0;
    end else if (last_edge) begin
      ldacn    <= 1'b0;
      ldac_cnt <= CW'(SCK_DIV - 1);
    end else if (!ldacn) begin
      if (ldac_cnt == '0) ldacn <= 1'b1;
      else                ldac_cnt <= ldac_cnt - CW'(1);
    end
  end
`else
  assign ldacn = 1'b1;
`endif

endmodule

// File: rtl/spi_dac_arbiter.sv
// Round-robin arbiter sharing one SPI DAC link between N_REQ requesters; the winner's
// {waddr, wdat} is serialized by spi_frame_tx. Optional latch strobe: SPI_DAC_ARB_LDAC_EN.
module spi_dac_arbiter
  import spi_dac_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 4,
  parameter int SCK_DIV    = 2,
  parameter int CSN_GAP    = 2
) (
  input logic               clk,
  input logic               arstn,
  spi_dac_arbiter_if.slave  bus
);

  localparam int FW = frame_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int PW = $clog2(N_REQ);

  if (FW > 32) begin : g_bad_fw
    $error("spi_dac_arbiter: ADDR_WIDTH+DATA_WIDTH must not exceed 32");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("spi_dac_arbiter: N_REQ must be in 2..8");
  end
  if (SCK_DIV < 1 || CSN_GAP < 1) begin : g_bad_timing
    $error("spi_dac_arbiter: SCK_DIV and CSN_GAP must be at least 1");
  end

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW:0]   cand;
  logic          found;
  logic          load;
  logic          tx_busy;
  logic [FW-1:0] frame;

  // Search starts at the pointer and wraps; the extra cand bit absorbs ptr+i overflow
  always_comb begin
    found = 1'b0;
    win   = ptr;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
      if (!found && bus.req[cand[PW-1:0]]) begin
        found = 1'b1;
        win   = cand[PW-1:0];
      end
    end
  end

  assign load  = found && !tx_busy;
  assign frame = {bus.waddr[win*ADDR_WIDTH +: ADDR_WIDTH],
                  bus.wdat[win*DATA_WIDTH +: DATA_WIDTH]};
  assign bus.busy = tx_busy;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      ptr     <= '0;
      bus.gnt <= '0;
    end else begin
      bus.gnt <= '0;
      if (load) begin
        bus.gnt <= N_REQ'(1) << win;
        ptr     <= (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
      end
    end
  end

  spi_frame_tx #(
    .FW      (FW),
    .SCK_DIV (SCK_DIV),
    .CSN_GAP (CSN_GAP)
  ) u_tx (
    .clk   (clk),
    .arstn (arstn),
    .load  (load),
    .frame (frame),
    .busy  (tx_busy),
    .done  (bus.done),
    .sck   (bus.sck),
    .mosi  (bus.mosi),
    .csn   (bus.csn),
    .ldacn (bus.ldacn)
  );

endmodule
